// File: rtl/ram_yanitlayici_pkg.sv
// rtl/ram_yanitlayici_pkg.sv - widths and state type for the line-wide RAM responder
`include "sabitler.vh"

package ram_yanitlayici_pkg;

  localparam int ADRES_GENISLIK = `ADRES_BIT;
  localparam int VERI_GENISLIK  = `VO_VERI_BIT;
  localparam int SATIR_OFSET    = `SATIR_OFSET_BIT;

  typedef enum logic [2:0] {
    BOSTA = `DURUM_BOSTA,
    OKUMA = `DURUM_OKUMA,
    YANIT = `DURUM_YANIT
  } durum_t;

endpackage

// File: rtl/ram_dizisi.sv
// rtl/ram_dizisi.sv - line array with one synchronous write port and one asynchronous read port
module ram_dizisi #(
  parameter int DERINLIK   = 256,
  parameter int GENISLIK   = 128,
  parameter int INDEKS_BIT = $clog2(DERINLIK)
) (
  input  logic                  clk_g,
  input  logic                  yaz_en,
  input  logic [INDEKS_BIT-1:0] yaz_satir,
  input  logic [GENISLIK-1:0]   yaz_veri,
  input  logic [INDEKS_BIT-1:0] oku_satir,
  output logic [GENISLIK-1:0]   oku_veri
);

  logic [GENISLIK-1:0] hucre [DERINLIK];

  always_ff @(posedge clk_g) begin
    if (yaz_en) begin
      hucre[yaz_satir] <= yaz_veri;
    end
  end

  assign oku_veri = hucre[oku_satir];

endmodule

// File: rtl/sabitler.vh
// rtl/sabitler.vh - shared widths and responder state encodings
`ifndef SABITLER_VH
`define SABITLER_VH

`define ADRES_BIT       32
`define VO_VERI_BIT     128
`define SATIR_OFSET_BIT 7

`define DURUM_BOSTA 3'd1
`define DURUM_OKUMA 3'd2
`define DURUM_YANIT 3'd4

`endif

// File: rtl/ram_yanitlayici.sv
// rtl/ram_yanitlayici.sv - responder serving the multiplier's RAM reads/writes plus a preload port
module ram_yanitlayici
  import ram_yanitlayici_pkg::*;
#(
  parameter int DERINLIK    = 256,
  parameter int OKU_GECIKME = 2,
  parameter int ADRES_BIT   = ADRES_GENISLIK,
  parameter int VO_VERI_BIT = VERI_GENISLIK
) (
  input  logic                   clk_g,
  input  logic                   resetn,
  input  logic [ADRES_BIT-1:0]   ram_adres_g,
  input  logic                   ram_oku_gecerli_g,
  input  logic                   ram_yaz_gecerli_g,
  input  logic [VO_VERI_BIT-1:0] ram_yaz_veri_g,
  output logic [VO_VERI_BIT-1:0] ram_oku_veri_c,
  output logic [ADRES_BIT-1:0]   ram_oku_adres_c,
  output logic                   ram_oku_gecerli_c,
  output logic                   ram_mesgul_c,
  input  logic                   yukle_gecerli_g,
  input  logic [ADRES_BIT-1:0]   yukle_adres_g,
  input  logic [VO_VERI_BIT-1:0] yukle_veri_g
);

  localparam int INDEKS_BIT = $clog2(DERINLIK);
  localparam int SATIR_UST  = SATIR_OFSET + INDEKS_BIT;
  localparam logic [3:0] SAYAC_BASLANGIC = 4'(OKU_GECIKME - 1);

  durum_t durum, durum_sonraki;
  logic [3:0] sayac;
  logic bekleyen, bekleyen_sonraki;
  logic yakala, cikis_yukle;

  logic [VO_VERI_BIT-1:0] dizi_veri, yakala_veri, kaynak_veri;
  logic [ADRES_BIT-1:0]   hizali_adres, yakala_adres, kaynak_adres;

  logic                   yaz_en;
  logic [INDEKS_BIT-1:0]  yaz_satir;
  logic [VO_VERI_BIT-1:0] yaz_veri;

  logic unused_bitler;
  assign unused_bitler = ^{ram_adres_g[SATIR_OFSET-1:0],
                           yukle_adres_g[SATIR_OFSET-1:0],
                           yukle_adres_g[ADRES_BIT-1:SATIR_UST]};

  // Request port has priority; a colliding preload write is dropped.
  assign yaz_en    = ram_yaz_gecerli_g | yukle_gecerli_g;
  assign yaz_satir = ram_yaz_gecerli_g ? ram_adres_g[SATIR_UST-1:SATIR_OFSET]
                                       : yukle_adres_g[SATIR_UST-1:SATIR_OFSET];
  assign yaz_veri  = ram_yaz_gecerli_g ? ram_yaz_veri_g : yukle_veri_g;

  ram_dizisi #(
    .DERINLIK  (DERINLIK),
    .GENISLIK  (VO_VERI_BIT),
    .INDEKS_BIT(INDEKS_BIT)
  ) u_dizi (
    .clk_g    (clk_g),
    .yaz_en   (yaz_en),
    .yaz_satir(yaz_satir),
    .yaz_veri (yaz_veri),
    .oku_satir(ram_adres_g[SATIR_UST-1:SATIR_OFSET]),
    .oku_veri (dizi_veri)
  );

  assign hizali_adres = {ram_adres_g[ADRES_BIT-1:SATIR_OFSET], {SATIR_OFSET{1'b0}}};

  always_comb begin
    durum_sonraki    = durum;
    bekleyen_sonraki = bekleyen;
    yakala           = 1'b0;
    case (durum)
      BOSTA: begin
        if (bekleyen || ram_oku_gecerli_g) begin
          yakala           = !bekleyen;
          bekleyen_sonraki = 1'b0;
          durum_sonraki    = (OKU_GECIKME == 1) ? YANIT : OKUMA;
        end
      end
      OKUMA: begin
        if (sayac == 4'd1) begin
          durum_sonraki = YANIT;
        end
      end
      YANIT: begin
        durum_sonraki = BOSTA;
        if (ram_oku_gecerli_g) begin
          yakala           = 1'b1;
          bekleyen_sonraki = 1'b1;
        end
      end
      default: durum_sonraki = BOSTA;
    endcase
    cikis_yukle = (durum_sonraki == YANIT) && (durum != YANIT);
  end

  // With latency 1 the response leaves BOSTA straight from the array, bypassing the snapshot.
  assign kaynak_veri  = yakala ? dizi_veri    : yakala_veri;
  assign kaynak_adres = yakala ? hizali_adres : yakala_adres;

  always_ff @(posedge clk_g) begin
    if (yakala) begin
      yakala_veri  <= dizi_veri;
      yakala_adres <= hizali_adres;
    end
  end

  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      durum           <= BOSTA;
      bekleyen        <= 1'b0;
      sayac           <= 4'd0;
      ram_oku_veri_c  <= '0;
      ram_oku_adres_c <= '0;
    end else begin
      durum    <= durum_sonraki;
      bekleyen <= bekleyen_sonraki;
      if ((durum == BOSTA) && (durum_sonraki != BOSTA)) begin
        sayac <= SAYAC_BASLANGIC;
      end else if (durum == OKUMA) begin
        sayac <= sayac - 4'd1;
      end
      if (cikis_yukle) begin
        ram_oku_veri_c  <= kaynak_veri;
        ram_oku_adres_c <= kaynak_adres;
      end
    end
  end

  assign ram_oku_gecerli_c = (durum == YANIT);
  assign ram_mesgul_c      = (durum != BOSTA) || bekleyen;

endmodule

// File: tb/tb_ram_yanitlayici.sv
// tb/tb_ram_yanitlayici.sv - randomized bench against a timing-rule reference model
module tb_ram_yanitlayici;
  import ram_yanitlayici_pkg::*;

  localparam int L  = 2;
  localparam int D  = 256;
  localparam int AB = ADRES_GENISLIK;
  localparam int VB = VERI_GENISLIK;

  logic clk_g = 1'b0;
  always #5 clk_g = ~clk_g;

  logic          resetn;
  logic [AB-1:0] ram_adres_g;
  logic          ram_oku_gecerli_g;
  logic          ram_yaz_gecerli_g;
  logic [VB-1:0] ram_yaz_veri_g;
  logic [VB-1:0] ram_oku_veri_c;
  logic [AB-1:0] ram_oku_adres_c;
  logic          ram_oku_gecerli_c;
  logic          ram_mesgul_c;
  logic          yukle_gecerli_g;
  logic [AB-1:0] yukle_adres_g;
  logic [VB-1:0] yukle_veri_g;

  ram_yanitlayici #(
    .DERINLIK   (D),
    .OKU_GECIKME(L),
    .ADRES_BIT  (AB),
    .VO_VERI_BIT(VB)
  ) dut (
    .clk_g            (clk_g),
    .resetn           (resetn),
    .ram_adres_g      (ram_adres_g),
    .ram_oku_gecerli_g(ram_oku_gecerli_g),
    .ram_yaz_gecerli_g(ram_yaz_gecerli_g),
    .ram_yaz_veri_g   (ram_yaz_veri_g),
    .ram_oku_veri_c   (ram_oku_veri_c),
    .ram_oku_adres_c  (ram_oku_adres_c),
    .ram_oku_gecerli_c(ram_oku_gecerli_c),
    .ram_mesgul_c     (ram_mesgul_c),
    .yukle_gecerli_g  (yukle_gecerli_g),
    .yukle_adres_g    (yukle_adres_g),
    .yukle_veri_g     (yukle_veri_g)
  );

  int testler = 0;
  int hatalar = 0;

  task automatic kontrol(input string etiket, input logic [VB-1:0] gozlenen, input logic [VB-1:0] beklenen);
    testler++;
    if (gozlenen !== beklenen) begin
      hatalar++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  // Reference: array contents plus the cycle number of the next response.
  logic [VB-1:0] ref_dizi [D];
  int            n = 0;
  int            m_valid_at = -10;
  int            m_busy_start = 1 << 30;
  logic [VB-1:0] m_snap_veri, m_veri;
  logic [AB-1:0] m_snap_adres, m_adres;
  bit            kontrol_acik = 1'b0;

  int            yanit_sayisi = 0;
  logic [VB-1:0] son_yanit_veri;
  logic [AB-1:0] son_yanit_adres;

  function automatic int satir_of(input logic [AB-1:0] a);
    return int'((a >> 7) % D);
  endfunction

  function automatic logic [AB-1:0] hizala(input logic [AB-1:0] a);
    return (a >> 7) << 7;
  endfunction

  function automatic logic [VB-1:0] rastgele_veri();
    return VB'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic adim();
    @(posedge clk_g);
    n++;
    if (!resetn) begin
      m_valid_at   = -10;
      m_busy_start = 1 << 30;
      m_veri       = '0;
      m_adres      = '0;
      kontrol_acik = 1'b1;
    end else if (ram_oku_gecerli_g && (m_valid_at <= n - 1)) begin
      m_snap_veri  = ref_dizi[satir_of(ram_adres_g)];
      m_snap_adres = hizala(ram_adres_g);
      m_busy_start = n;
      // A read arriving as the response leaves waits one extra idle cycle.
      m_valid_at   = (m_valid_at == n - 1) ? n + L : n + L - 1;
    end
    if (ram_yaz_gecerli_g) ref_dizi[satir_of(ram_adres_g)] = ram_yaz_veri_g;
    else if (yukle_gecerli_g) ref_dizi[satir_of(yukle_adres_g)] = yukle_veri_g;
    @(negedge clk_g);
    if (kontrol_acik) begin
      if (n == m_valid_at) begin
        m_veri  = m_snap_veri;
        m_adres = m_snap_adres;
      end
      kontrol("gecerli", VB'(ram_oku_gecerli_c), VB'(n == m_valid_at));
      kontrol("mesgul", VB'(ram_mesgul_c), VB'((n >= m_busy_start) && (n <= m_valid_at)));
      kontrol("veri", ram_oku_veri_c, m_veri);
      kontrol("adres", VB'(ram_oku_adres_c), VB'(m_adres));
    end
    if (ram_oku_gecerli_c === 1'b1) begin
      yanit_sayisi++;
      son_yanit_veri  = ram_oku_veri_c;
      son_yanit_adres = ram_oku_adres_c;
    end
  endtask

  task automatic bosalt();
    ram_oku_gecerli_g = 1'b0;
    ram_yaz_gecerli_g = 1'b0;
    yukle_gecerli_g   = 1'b0;
  endtask

  task automatic yukle(input logic [AB-1:0] a, input logic [VB-1:0] v);
    yukle_gecerli_g = 1'b1;
    yukle_adres_g   = a;
    yukle_veri_g    = v;
    adim();
    bosalt();
  endtask

  task automatic oku(input logic [AB-1:0] a, input int bekle);
    ram_oku_gecerli_g = 1'b1;
    ram_adres_g       = a;
    adim();
    bosalt();
    for (int i = 0; i < bekle; i++) adim();
  endtask

  initial begin
    int onceki;
    int sayi;
    logic [VB-1:0] eski5;

    resetn         = 1'b0;
    ram_adres_g    = '0;
    ram_yaz_veri_g = '0;
    yukle_adres_g  = '0;
    yukle_veri_g   = '0;
    bosalt();
    adim();
    adim();
    kontrol("reset_veri", ram_oku_veri_c, '0);
    kontrol("reset_mesgul", VB'(ram_mesgul_c), '0);
    resetn = 1'b1;

    for (int i = 0; i < D; i++) yukle(AB'((i << 7) | $urandom_range(0, 127)), rastgele_veri());

    yukle(32'h180, {16{8'hA5}});
    oku(32'h180, 4);
    kontrol("a5_veri", son_yanit_veri, {16{8'hA5}});
    kontrol("a5_adres", VB'(son_yanit_adres), VB'(32'h180));

    ram_yaz_gecerli_g = 1'b1;
    ram_adres_g       = 32'h1FF;
    ram_yaz_veri_g    = VB'(128'h1234);
    adim();
    bosalt();
    oku(32'h180, 4);
    kontrol("ofset_veri", son_yanit_veri, VB'(128'h1234));

    eski5 = rastgele_veri();
    yukle(32'h280, eski5);
    ram_oku_gecerli_g = 1'b1;
    ram_adres_g       = 32'h280;
    adim();
    bosalt();
    ram_yaz_gecerli_g = 1'b1;
    ram_yaz_veri_g    = VB'(128'hFF);
    adim();
    bosalt();
    for (int i = 0; i < 3; i++) adim();
    kontrol("anlik_eski", son_yanit_veri, eski5);
    oku(32'h280, 4);
    kontrol("anlik_yeni", son_yanit_veri, VB'(128'hFF));

    onceki = -1;
    sayi   = yanit_sayisi;
    ram_oku_gecerli_g = 1'b1;
    ram_adres_g       = 32'h300;
    for (int i = 0; i < 20; i++) begin
      adim();
      if (ram_oku_gecerli_c === 1'b1) begin
        if (onceki >= 0) kontrol("aralik", VB'(n - onceki), VB'(L + 1));
        onceki = n;
      end
    end
    bosalt();
    for (int i = 0; i < 5; i++) adim();
    kontrol("surekli_yanit", VB'(yanit_sayisi - sayi), VB'((20 - L) / (L + 1) + 1));

    ram_oku_gecerli_g = 1'b1;
    ram_adres_g       = 32'h180;
    adim();
    bosalt();
    resetn = 1'b0;
    adim();
    kontrol("rst_mesgul", VB'(ram_mesgul_c), '0);
    resetn = 1'b1;
    sayi = yanit_sayisi;
    for (int i = 0; i < 5; i++) adim();
    kontrol("rst_yanit_yok", VB'(yanit_sayisi), VB'(sayi));
    oku(32'h180, 4);
    kontrol("rst_sonra_veri", son_yanit_veri, VB'(128'h1234));

    yukle(32'h100, {8{16'hC0DE}});
    oku(AB'((D + 2) << 7), 4);
    kontrol("sarma_veri", son_yanit_veri, {8{16'hC0DE}});

    for (int i = 0; i < 3000; i++) begin
      logic [AB-1:0] a;
      a = AB'($urandom()) & ~AB'(32'h7F80);
      ram_adres_g       = a | AB'($urandom_range(0, 7) << 7);
      ram_oku_gecerli_g = ($urandom_range(0, 9) < 4);
      ram_yaz_gecerli_g = ($urandom_range(0, 9) < 3);
      ram_yaz_veri_g    = rastgele_veri();
      yukle_gecerli_g   = ($urandom_range(0, 9) < 3);
      yukle_adres_g     = (AB'($urandom()) & ~AB'(32'h7F80)) | AB'($urandom_range(0, 7) << 7);
      yukle_veri_g      = rastgele_veri();
      resetn            = ($urandom_range(0, 99) != 0);
      adim();
    end
    resetn = 1'b1;
    bosalt();
    for (int i = 0; i < 6; i++) adim();

    $display("[TB] %0d tests run, %0d failed", testler, hatalar);
    $finish;
  end

endmodule

// File: doc/ram_yanitlayici.md
Name: ram_yanitlayici

Overview:
- Line-wide RAM responder. It sits on the far end of the matrix-multiplier RAM interface and serves that initiator's read and write requests.
- It holds an internal array of VO_VERI_BIT-wide lines. Reads return data after a fixed, parameterised latency and drive busy while a read is in flight. Writes complete in a single cycle.
- A side load port lets the top level or the bench preload matrices before a multiply starts.

Parameters:
- DERINLIK, 256, number of lines in the array; must be a power of two.
- OKU_GECIKME, 2, read latency in cycles; range 1..15.
- ADRES_BIT, `ADRES_BIT (32), address width. Taken from sabitler.vh.
- VO_VERI_BIT, `VO_VERI_BIT (128), line width in bits. Taken from sabitler.vh.

Ports:
- clk_g  in  1  single clock; every register updates on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- ram_adres_g  in  ADRES_BIT  bit-granular request address. Bits [6:0] are ignored; line index = bits [7+log2(DERINLIK)-1:7].
- ram_oku_gecerli_g  in  1  read request strobe.
- ram_yaz_gecerli_g  in  1  write request strobe.
- ram_yaz_veri_g  in  VO_VERI_BIT  write data.
- ram_oku_veri_c  out  VO_VERI_BIT  read data.
- ram_oku_adres_c  out  ADRES_BIT  line-aligned address of the returned data; bits [6:0] are 0.
- ram_oku_gecerli_c  out  1  read response valid, one cycle per accepted read.
- ram_mesgul_c  out  1  a read is in flight; new reads are not accepted.
- yukle_gecerli_g  in  1  preload write strobe.
- yukle_adres_g  in  ADRES_BIT  preload address; same line mapping as ram_adres_g.
- yukle_veri_g  in  VO_VERI_BIT  preload data.

Behaviour:
- Reset (resetn low at an edge):
  - state = BOSTA.
  - ram_oku_gecerli_c = 0, ram_mesgul_c = 0, ram_oku_veri_c = 0, ram_oku_adres_c = 0, latency counter = 0.
  - Array contents are not cleared.
  - A read in flight when reset is applied is dropped; no response is ever issued for it.
- States: BOSTA, OKUMA, YANIT.
- BOSTA:
  - If ram_oku_gecerli_g is high at an edge, the read is accepted.
  - On acceptance: array[line] is captured into the data register, the line-aligned address is captured, and the counter is set to OKU_GECIKME-1.
  - If OKU_GECIKME=1, go directly to YANIT; otherwise go to OKUMA.
- OKUMA:
  - Counter decrements every cycle; go to YANIT when it reaches 1.
  - ram_mesgul_c = 1.
  - ram_oku_gecerli_g is ignored; no queueing.
- YANIT:
  - ram_oku_gecerli_c = 1 for exactly one cycle; ram_oku_veri_c and ram_oku_adres_c are valid in that cycle.
  - ram_mesgul_c = 1 in this cycle.
  - Next state is BOSTA. A new read may be accepted at the edge that leaves YANIT. It is registered as pending and is served starting in BOSTA's next cycle.
- Latency: for a read sampled at edge k, ram_oku_gecerli_c is high in the cycle following edge k+OKU_GECIKME-1.
  - Busy is high from the cycle after edge k through the valid cycle inclusive.
  - Busy is low the cycle after valid, unless a back-to-back read was accepted.
- ram_oku_veri_c and ram_oku_adres_c hold their last value outside the valid cycle.
- Snapshot rule: read data is taken at the acceptance edge. A write to the same line during OKUMA or YANIT does not change the returned data.
- Write port:
  - Independent of the read state machine and accepted in every state, including while busy.
  - array[line] <= ram_yaz_veri_g at the edge where ram_yaz_gecerli_g = 1.
  - Writes never raise busy.
- Simultaneous read and write to the same line at the same edge: the read returns the OLD contents. The write takes effect at that edge.
- Load port:
  - Same single-cycle write into the array, on yukle_adres_g.
  - If yukle_gecerli_g and ram_yaz_gecerli_g are both high at one edge, the request port wins and the load write is dropped.
- Out-of-range addresses: address bits above the line index are ignored, so lines wrap modulo DERINLIK. There is no error indication.
- Reset has no effect on writes, because the array is not reset.

Decomposition:
- sabitler.vh supplies ADRES_BIT and VO_VERI_BIT.
- Add to sabitler.vh:
  - SATIR_OFSET_BIT = 7 (line offset width).
  - the BOSTA/OKUMA/YANIT encodings, one-hot 'd1/'d2/'d4.
- Sub-module ram_dizisi: the array with one synchronous write port and one asynchronous read port. The write-port mux (request vs load) stays in the parent.

Test Plan:
- Preload line 3 with 128'hA5..A5 via the load port. Read address 32'h180 with OKU_GECIKME=2.
  - Expect: valid high exactly one cycle, 2 cycles after the request edge.
  - Expect: data A5..A5, ram_oku_adres_c = 32'h180, busy high for 2 cycles.
- Request-port write of 128'h1234 to 32'h1FF, then read 32'h180.
  - Expect: 128'h1234 returned; offset bits [6:0] are ignored.
- Read line 5, then write line 5 with 128'hFF during OKUMA.
  - Expect: response carries the pre-write data.
  - Expect: a second read of line 5 returns 128'hFF.
- Hold ram_oku_gecerli_g high continuously.
  - Expect: responses spaced by exactly OKU_GECIKME+1 cycles.
  - Expect: reads requested during busy produce no extra responses.
- Assert resetn low during OKUMA.
  - Expect: no valid pulse and busy = 0 after the reset edge.
  - Expect: previously written data still readable.
- Read address (DERINLIK+2)<<7.
  - Expect: line 2 data returned, because the address wraps.
